// File: rtl/multi_clk_gen_pkg.sv
// multi_clk_gen_pkg: channel state, channel config record and count helper shared by multi_clk_gen.
package multi_clk_gen_pkg;
    localparam int CFG_CNT_W = 16;
    typedef enum logic [1:0] {IDLE, PHASE, HIGH, LOW} ch_state_e;
    typedef struct packed {
        logic                 en;
        logic [CFG_CNT_W-1:0] high;
        logic [CFG_CNT_W-1:0] low;
        logic [CFG_CNT_W-1:0] phase;
    } ch_cfg_t;
    function automatic logic [CFG_CNT_W-1:0] min1(input logic [CFG_CNT_W-1:0] v);
        return (v == '0) ? CFG_CNT_W'(1) : v;
    endfunction
endpackage

// File: rtl/clk_gen_ch.sv
// clk_gen_ch: one generated-clock channel (shadow config, pending flag, IDLE/PHASE/HIGH/LOW FSM).
// The PHASE start delay is built only when MULTI_CLK_GEN_PHASE_EN is defined.
module clk_gen_ch
    import multi_clk_gen_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    i_load,
    input  ch_cfg_t i_cfg,
    output logic    o_pending,
    output logic    o_clk_out,
    output logic    o_rise_tick,
    output logic    o_fall_tick
);
    ch_state_e            r_state, w_state_nxt;
    ch_cfg_t              r_shadow, w_cfg;
    logic [CFG_CNT_W-1:0] r_cnt, w_cnt_nxt, r_high, r_low, w_high_nxt, w_low_nxt;
    logic                 r_pending, r_clk_out, r_rise, r_fall;
    logic                 w_last, w_apply, w_out_high, w_rise_nxt, w_fall_nxt;
`ifdef MULTI_CLK_GEN_PHASE_EN
    assign w_cfg = i_cfg;
`else
    logic w_unused_phase;
    assign w_cfg = {i_cfg.en, i_cfg.high, i_cfg.low, CFG_CNT_W'(0)};
    assign w_unused_phase = ^{i_cfg.phase, r_shadow.phase};
`endif
    assign w_last  = (r_cnt == CFG_CNT_W'(1));
    // A running channel only takes new settings on its last LOW cycle, so no phase is ever cut short.
    assign w_apply = r_pending && (r_state == IDLE || (r_state == LOW && w_last));
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = (r_cnt > CFG_CNT_W'(1)) ? r_cnt - CFG_CNT_W'(1) : r_cnt;
        w_high_nxt  = w_apply ? min1(r_shadow.high) : r_high;
        w_low_nxt   = w_apply ? min1(r_shadow.low) : r_low;
        case (r_state)
            IDLE: if (w_apply && r_shadow.en) begin
`ifdef MULTI_CLK_GEN_PHASE_EN
                w_state_nxt = (r_shadow.phase != '0) ? PHASE : HIGH;
                w_cnt_nxt   = (r_shadow.phase != '0) ? r_shadow.phase : w_high_nxt;
`else
                w_state_nxt = HIGH;
                w_cnt_nxt   = w_high_nxt;
`endif
            end
`ifdef MULTI_CLK_GEN_PHASE_EN
            PHASE: if (w_last) begin
                w_state_nxt = HIGH;
                w_cnt_nxt   = r_high;
            end
`endif
            HIGH: if (w_last) begin
                w_state_nxt = LOW;
                w_cnt_nxt   = r_low;
            end
            LOW: if (w_last) begin
                w_state_nxt = (w_apply && !r_shadow.en) ? IDLE : HIGH;
                w_cnt_nxt   = w_high_nxt;
            end
            default: w_state_nxt = IDLE;
        endcase
    end
    always_comb begin
        w_out_high = (r_state == HIGH);
        w_rise_nxt = w_out_high && !r_clk_out;
        w_fall_nxt = !w_out_high && r_clk_out;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_high    <= '0;
            r_low     <= '0;
            r_shadow  <= '0;
            r_pending <= 1'b0;
            r_clk_out <= 1'b0;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_high    <= w_high_nxt;
            r_low     <= w_low_nxt;
            r_clk_out <= w_out_high;
            r_rise    <= w_rise_nxt;
            r_fall    <= w_fall_nxt;
            r_pending <= i_load || (r_pending && !w_apply);
            if (i_load) r_shadow <= w_cfg;
        end
    end
    assign o_pending   = r_pending;
    assign o_clk_out   = r_clk_out;
    assign o_rise_tick = r_rise;
    assign o_fall_tick = r_fall;
endmodule

// File: rtl/multi_clk_gen.sv
// multi_clk_gen: NUM_CH independent programmable clock generators behind one valid/ready config port.
// Define MULTI_CLK_GEN_PHASE_EN to enable the per-channel start delay (cfg_phase).
module multi_clk_gen
    import multi_clk_gen_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = CFG_CNT_W
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          cfg_valid,
    output logic                                          cfg_ready,
    input  logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0]  cfg_ch,
    input  logic                                          cfg_en,
    input  logic [CNT_W-1:0]                              cfg_high,
    input  logic [CNT_W-1:0]                              cfg_low,
    input  logic [CNT_W-1:0]                              cfg_phase,
    output logic [NUM_CH-1:0]                             clk_out,
    output logic [NUM_CH-1:0]                             rise_tick,
    output logic [NUM_CH-1:0]                             fall_tick,
    output logic [NUM_CH-1:0]                             pending
);
    localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    ch_cfg_t w_cfg;
    logic    w_ch_ok;
    assign w_cfg     = {cfg_en, cfg_high, cfg_low, cfg_phase};
    assign w_ch_ok   = (int'(cfg_ch) < NUM_CH);
    assign cfg_ready = !rst && w_ch_ok && !pending[cfg_ch];
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_gen_ch u_ch (
            .clk         (clk),
            .rst         (rst),
            .i_load      (cfg_valid && cfg_ready && cfg_ch == CH_W'(i)),
            .i_cfg       (w_cfg),
            .o_pending   (pending[i]),
            .o_clk_out   (clk_out[i]),
            .o_rise_tick (rise_tick[i]),
            .o_fall_tick (fall_tick[i])
        );
    end
endmodule

// File: tb/tb_multi_clk_gen.sv
// tb_multi_clk_gen: vector table, corner sequences and random traffic for multi_clk_gen,
// every cycle compared against a waveform-queue model of each channel.
module tb_multi_clk_gen;
    localparam int NUM_CH = 4;
`ifdef MULTI_CLK_GEN_PHASE_EN
    localparam bit PH_ON = 1'b1;
`else
    localparam bit PH_ON = 1'b0;
`endif
    typedef struct {
        int ch;
        bit en;
        int hi;
        int lo;
        int ph;
        int exp_delay;
        int exp_period;
        int exp_high;
    } vec_t;
    logic              clk = 1'b0;
    logic              rst, cfg_valid, cfg_ready, cfg_en;
    logic [1:0]        cfg_ch;
    logic [15:0]       cfg_high, cfg_low, cfg_phase;
    logic [NUM_CH-1:0] clk_out, rise_tick, fall_tick, pending;
    logic [63:0]       m_buf [NUM_CH];
    int                m_len [NUM_CH];
    bit                m_run [NUM_CH];
    bit                m_pend [NUM_CH];
    bit                m_prev [NUM_CH];
    bit                m_en [NUM_CH];
    int                m_hi [NUM_CH];
    int                m_lo [NUM_CH];
    int                m_ph [NUM_CH];
    int                m_cur_hi [NUM_CH];
    int                m_cur_lo [NUM_CH];
    logic [NUM_CH-1:0] e_out, e_rise, e_fall, e_pend;
    int                n_tests = 0;
    int                n_fail = 0;
    vec_t              tbl [6];

    multi_clk_gen #(.NUM_CH(NUM_CH), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_en    (cfg_en),
        .cfg_high  (cfg_high),
        .cfg_low   (cfg_low),
        .cfg_phase (cfg_phase),
        .clk_out   (clk_out),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ones(input int n);
        return (64'(1) << n) - 64'(1);
    endfunction

    function automatic int norm(input int n);
        return (n == 0) ? 1 : n;
    endfunction

    // Each channel is a queue of future clk_out samples; a period is appended whenever the queue drains.
    task automatic model_edge(input bit r, input bit acc, input int ch, input bit en,
                              input int hi, input int lo, input int ph);
        for (int c = 0; c < NUM_CH; c++) begin
            logic v;
            if (r) begin
                m_buf[c] = '0; m_len[c] = 0; m_run[c] = 0; m_pend[c] = 0; m_prev[c] = 0;
                e_out[c] = 0; e_rise[c] = 0; e_fall[c] = 0;
            end else begin
                v = (m_len[c] > 0) ? m_buf[c][0] : 1'b0;
                if (m_len[c] > 0) begin
                    m_buf[c] = m_buf[c] >> 1;
                    m_len[c]--;
                end
                if (m_pend[c] && (!m_run[c] || m_len[c] == 0)) begin
                    m_pend[c] = 0;
                    if (m_en[c]) begin
                        m_cur_hi[c] = m_hi[c];
                        m_cur_lo[c] = m_lo[c];
                        m_buf[c] = ones(m_hi[c]) << (m_run[c] ? 0 : m_ph[c]);
                        m_len[c] = m_hi[c] + m_lo[c] + (m_run[c] ? 0 : m_ph[c]);
                        m_run[c] = 1;
                    end else m_run[c] = 0;
                end else if (m_run[c] && m_len[c] == 0) begin
                    m_buf[c] = ones(m_cur_hi[c]);
                    m_len[c] = m_cur_hi[c] + m_cur_lo[c];
                end
                e_out[c]  = v;
                e_rise[c] = v && !m_prev[c];
                e_fall[c] = !v && m_prev[c];
                m_prev[c] = v;
            end
        end
        if (acc) begin
            m_pend[ch] = 1;
            m_en[ch]   = en;
            m_hi[ch]   = norm(hi);
            m_lo[ch]   = norm(lo);
            m_ph[ch]   = PH_ON ? ph : 0;
        end
        for (int c = 0; c < NUM_CH; c++) e_pend[c] = m_pend[c];
    endtask

    task automatic tick();
        bit r, acc, en, rdy;
        int ch, hi, lo, ph;
        #1;
        r   = rst;
        ch  = int'(cfg_ch);
        en  = cfg_en;
        hi  = int'(cfg_high);
        lo  = int'(cfg_low);
        ph  = int'(cfg_phase);
        rdy = !r && !m_pend[ch];
        acc = cfg_valid && rdy;
        chk("cfg_ready", 32'(cfg_ready), 32'(rdy));
        @(posedge clk);
        model_edge(r, acc, ch, en, hi, lo, ph);
        #1;
        chk("clk_out", 32'(clk_out), 32'(e_out));
        chk("rise_tick", 32'(rise_tick), 32'(e_rise));
        chk("fall_tick", 32'(fall_tick), 32'(e_fall));
        chk("pending", 32'(pending), 32'(e_pend));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cfg_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send(input int ch, input bit en, input int hi, input int lo, input int ph);
        cfg_ch    = 2'(ch);
        cfg_en    = en;
        cfg_high  = 16'(hi);
        cfg_low   = 16'(lo);
        cfg_phase = 16'(ph);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_high(input int ch);
        int n = 0;
        while (!clk_out[ch] && n < 20) begin
            tick();
            n++;
        end
        chk("wait_high", 32'(clk_out[ch]), 32'd1);
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_en = 1'b0;
        cfg_high = '0; cfg_low = '0; cfg_phase = '0;
        tbl[0] = '{0, 1'b1, 2, 2, 0, 2, 4, 2};
        tbl[1] = '{1, 1'b1, 1, 3, 5, PH_ON ? 7 : 2, 4, 1};
        tbl[2] = '{2, 1'b1, 0, 0, 0, 2, 2, 1};
        tbl[3] = '{3, 1'b1, 3, 1, 7, PH_ON ? 9 : 2, 4, 3};
        tbl[4] = '{0, 1'b1, 5, 0, 0, 2, 6, 5};
        tbl[5] = '{1, 1'b0, 3, 3, 0, 0, 0, 0};
        tick();
        chk("reset_out", 32'(clk_out), 32'd0);
        chk("reset_pending", 32'(pending), 32'd0);
        for (int t = 0; t < 6; t++) begin
            int n, per, hc, c;
            bit found;
            c = tbl[t].ch;
            do_reset();
            send(c, tbl[t].en, tbl[t].hi, tbl[t].lo, tbl[t].ph);
            n = 0; found = 0; per = 0; hc = 0;
            while (!found && n < 40) begin
                tick();
                n++;
                found = rise_tick[c];
            end
            if (found) begin
                hc = 1;
                do begin
                    tick();
                    per++;
                    if (!rise_tick[c]) hc += int'(clk_out[c]);
                end while (!rise_tick[c] && per < 40);
            end
            chk("tbl_delay", found ? n : 0, tbl[t].exp_delay);
            chk("tbl_period", per, tbl[t].exp_period);
            chk("tbl_high", hc, tbl[t].exp_high);
        end
        begin : seq_reconfig
            logic [7:0] pat;
            logic [2:0] pb;
            do_reset();
            send(0, 1, 2, 2, 0);
            wait_high(0);
            send(0, 1, 3, 1, 0);
            pat = '0; pb = '0;
            pat[0] = clk_out[0];
            pb[0] = pending[0];
            for (int i = 1; i < 8; i++) begin
                tick();
                pat[i] = clk_out[0];
                if (i < 3) pb[i] = pending[0];
            end
            chk("reconfig_wave", 32'(pat), 32'hB9);
            chk("reconfig_pending", 32'(pb), 32'b011);
        end
        begin : seq_disable
            int s;
            do_reset();
            send(0, 1, 0, 0, 0);
            s = 0;
            for (int i = 0; i < 6; i++) begin
                tick();
                s += int'(clk_out[0]);
            end
            chk("toggle_ones", s, 3);
            send(0, 0, 1, 1, 0);
            for (int i = 0; i < 4; i++) tick();
            s = 0;
            for (int i = 0; i < 8; i++) begin
                tick();
                s += int'(clk_out[0]);
            end
            chk("disabled_out", s, 0);
            chk("disabled_pending", 32'(pending[0]), 32'd0);
        end
        begin : seq_reset_mid_high
            do_reset();
            send(0, 1, 2, 2, 0);
            wait_high(0);
            rst = 1'b1;
            tick();
            chk("rst_clk_out", 32'(clk_out), 32'd0);
            chk("rst_rise", 32'(rise_tick), 32'd0);
            chk("rst_fall", 32'(fall_tick), 32'd0);
            chk("rst_pending", 32'(pending), 32'd0);
            rst = 1'b0;
            cfg_ch = 2'd0;
            #1;
            chk("rst_ready", 32'(cfg_ready), 32'd1);
            tick();
        end
        begin : seq_independent
            int s0, s1;
            do_reset();
            send(0, 1, 2, 2, 0);
            tick();
            tick();
            send(1, 1, 1, 3, 5);
            for (int i = 0; i < 20; i++) tick();
            s0 = 0; s1 = 0;
            for (int i = 0; i < 16; i++) begin
                tick();
                s0 += int'(clk_out[0]);
                s1 += int'(clk_out[1]);
            end
            chk("indep_ch0", s0, 8);
            chk("indep_ch1", s1, 4);
        end
        do_reset();
        for (int k = 0; k < 2500; k++) begin
            rst       = ($urandom_range(0, 299) == 0);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ch    = 2'($urandom_range(0, 3));
            cfg_en    = ($urandom_range(0, 5) != 0);
            cfg_high  = 16'($urandom_range(0, 6));
            cfg_low   = 16'($urandom_range(0, 6));
            cfg_phase = 16'($urandom_range(0, 8));
            tick();
        end
        rst = 1'b0;
        cfg_valid = 1'b0;
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
